// File: rtl/tagged_packet_fifo.sv
// tagged_packet_fifo: packet-aware output FIFO for the AES-GCM datapath.
// Words are written speculatively and only become visible to the reader once
// committed. Encrypt packets commit word by word. Decrypt packets wait for the
// tag verdict: a good tag commits the whole packet, a bad tag rolls it back.
// Optional build macro: FIFO_DROP_CNT_EN adds a saturating 16-bit drop_count.
//
// Handshake: a write is accepted on a rising clk edge where w_en & w_ready.
// A read is accepted where r_en & !empty, and data_out/data_valid follow one
// cycle later. w_ready depends only on state and pointers, never on w_en.
module tagged_packet_fifo #(
  parameter int WIDTH       = 128,
  parameter int ADDR_W      = 8,
  parameter int LAST_THRESH = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              w_en,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              pkt_end,
  input  logic              enc_dec,
  input  logic              tag_valid,
  input  logic              tag_ok,
  output logic              w_ready,
  input  logic              r_en,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              last,
  output logic [ADDR_W:0]   count,
  output logic              pkt_pending,
  output logic              drop_pulse,
  output logic [1:0]        fsm_state
`ifdef FIFO_DROP_CNT_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_CNT  = LAST_THRESH[ADDR_W:0];

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    WAIT_TAG = 2'd2
  } state_t;

  state_t            state;
  logic              mode;
  logic [ADDR_W:0]   w_ptr;
  logic [ADDR_W:0]   c_ptr;
  logic [ADDR_W:0]   r_ptr;
  logic [ADDR_W:0]   tot_occ;
  logic [ADDR_W:0]   com_occ;
  logic              wr_acc;
  logic              rd_acc;
  logic              eff_mode;
  logic              tag_fire;
  logic [WIDTH-1:0]  mem [0:DEPTH-1];

  assign tot_occ     = w_ptr - r_ptr;
  assign com_occ     = c_ptr - r_ptr;
  assign full        = (tot_occ == DEPTH_CNT);
  assign empty       = (com_occ == '0);
  assign last        = (com_occ == LAST_CNT);
  assign count       = com_occ;
  assign w_ready     = !full && (state != WAIT_TAG);
  assign pkt_pending = (state != IDLE);
  assign fsm_state   = state;
  assign wr_acc      = w_en && w_ready;
  assign rd_acc      = r_en && !empty;
  // The first word of a packet uses the live enc_dec pin; later words use the latched mode.
  assign eff_mode    = (state == IDLE) ? enc_dec : mode;
  assign tag_fire    = tag_valid && (state == WAIT_TAG);

  // Storage array: written on accepted writes, never reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr[ADDR_W-1:0]] <= data_in;
  end

  // Pointers, packet FSM, read port and rollback pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      mode       <= 1'b0;
      w_ptr      <= '0;
      c_ptr      <= '0;
      r_ptr      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;

      // Writes and tag verdicts never coincide: w_ready is low in WAIT_TAG.
      if (wr_acc) begin
        w_ptr <= w_ptr + 1'b1;
        if (!eff_mode) c_ptr <= w_ptr + 1'b1;
      end
      if (tag_fire) begin
        if (tag_ok) begin
          c_ptr <= w_ptr;
        end else begin
          w_ptr      <= c_ptr;
          drop_pulse <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (wr_acc) begin
            mode <= enc_dec;
            if (pkt_end) state <= enc_dec ? WAIT_TAG : IDLE;
            else         state <= FILL;
          end
        end
        FILL: begin
          if (wr_acc && pkt_end) state <= mode ? WAIT_TAG : IDLE;
        end
        WAIT_TAG: begin
          if (tag_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A read in the drop cycle wins over the zero-on-bad-tag clear.
      if (rd_acc) begin
        data_out   <= mem[r_ptr[ADDR_W-1:0]];
        r_ptr      <= r_ptr + 1'b1;
        data_valid <= 1'b1;
      end else begin
        data_valid <= 1'b0;
        if (tag_fire && !tag_ok) data_out <= '0;
      end
    end
  end

`ifdef FIFO_DROP_CNT_EN
  // Saturating count of rolled-back packets.
  always_ff @(posedge clk) begin
    if (!rstn)                                   drop_count <= '0;
    else if (drop_pulse && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_tagged_packet_fifo.sv
// Directed bench for tagged_packet_fifo (WIDTH=32, ADDR_W=3, DEPTH=8).
// Committed words go to exp_q; speculative decrypt words wait in pend_q until
// the verdict moves or discards them. A monitor pops exp_q on data_valid.
module tb_tagged_packet_fifo;

  localparam int W  = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic          w_en;
  logic [W-1:0]  data_in;
  logic          pkt_end;
  logic          enc_dec;
  logic          tag_valid;
  logic          tag_ok;
  logic          w_ready;
  logic          r_en;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic          last;
  logic [AW:0]   count;
  logic          pkt_pending;
  logic          drop_pulse;
  logic [1:0]    fsm_state;
`ifdef FIFO_DROP_CNT_EN
  logic [15:0]   drop_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pend_q[$];

  tagged_packet_fifo #(.WIDTH(W), .ADDR_W(AW), .LAST_THRESH(2)) dut (
    .clk(clk), .rstn(rstn), .w_en(w_en), .data_in(data_in), .pkt_end(pkt_end),
    .enc_dec(enc_dec), .tag_valid(tag_valid), .tag_ok(tag_ok), .w_ready(w_ready),
    .r_en(r_en), .data_out(data_out), .data_valid(data_valid), .full(full),
    .empty(empty), .last(last), .count(count), .pkt_pending(pkt_pending),
    .drop_pulse(drop_pulse), .fsm_state(fsm_state)
`ifdef FIFO_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every data_valid must match the oldest committed word.
  always @(posedge clk) begin
    #1;
    if (data_valid === 1'b1) begin
      n_checks++;
      assert (exp_q.size() != 0) begin
        n_pass++;
      end else begin
        $error("FAIL rd_unexpected: observed %0h expected no read data", data_out);
      end
      if (exp_q.size() != 0) chk("rd_data", data_out, exp_q.pop_front());
    end
  end

  // Driver tasks: each starts and ends at a falling edge.
  task automatic cyc(input logic w, input logic [W-1:0] d, input logic pe, input logic ed,
                     input logic r, input logic tv, input logic ok);
    w_en = w; data_in = d; pkt_end = pe; enc_dec = ed; r_en = r; tag_valid = tv; tag_ok = ok;
    @(negedge clk);
    w_en = 1'b0; data_in = '0; pkt_end = 1'b0; enc_dec = 1'b0;
    r_en = 1'b0; tag_valid = 1'b0; tag_ok = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr_enc(input logic [W-1:0] d, input logic pe);
    cyc(1'b1, d, pe, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(d);
  endtask

  task automatic wr_dec(input logic [W-1:0] d, input logic pe, input logic ed);
    cyc(1'b1, d, pe, ed, 1'b0, 1'b0, 1'b0);
    pend_q.push_back(d);
  endtask

  task automatic wr_drop(input logic [W-1:0] d);
    cyc(1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic tag(input logic ok, input logic r);
    cyc(1'b0, '0, 1'b0, 1'b0, r, 1'b1, ok);
    if (ok) begin
      while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
    end else begin
      pend_q.delete();
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    pend_q.delete();
  endtask

  initial begin
    w_en = 1'b0; data_in = '0; pkt_end = 1'b0; enc_dec = 1'b0;
    r_en = 1'b0; tag_valid = 1'b0; tag_ok = 1'b0; rstn = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_w_ready", w_ready, 1'b1);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 1'b0);
    chk("rst_drop_pulse", drop_pulse, 1'b0);
    chk("rst_pending", pkt_pending, 1'b0);

    // Encrypt path: each word readable the cycle after it is written
    wr_enc(32'h1, 1'b0);
    chk("enc_count1", count, 1);
    wr_enc(32'h2, 1'b0);
    chk("enc_last", last, 1'b1);
    wr_enc(32'h3, 1'b1);
    chk("enc_count3", count, 3);
    chk("enc_pending", pkt_pending, 1'b0);
    rd();
    chk("enc_dv_latency", data_valid, 1'b1);
    rd();
    rd();
    chk("enc_drained", count, 0);
    chk("enc_empty", empty, 1'b1);
    idle();
    chk("enc_dv_drop", data_valid, 1'b0);

    // Decrypt commit: mode latched on first word, later enc_dec ignored
    wr_dec(32'hA0, 1'b0, 1'b1);
    wr_dec(32'hA1, 1'b0, 1'b0);
    wr_dec(32'hA2, 1'b0, 1'b0);
    wr_dec(32'hA3, 1'b1, 1'b0);
    chk("dec_count", count, 0);
    chk("dec_empty", empty, 1'b1);
    chk("dec_pending", pkt_pending, 1'b1);
    chk("dec_w_ready", w_ready, 1'b0);
    chk("dec_state", fsm_state, 2);
    wr_drop(32'hFF);
    rd();
    chk("dec_no_spec_read", data_valid, 1'b0);
    tag(1'b1, 1'b0);
    chk("dec_commit_count", count, 4);
    chk("dec_commit_last", last, 1'b0);
    chk("dec_commit_idle", pkt_pending, 1'b0);
    repeat (4) rd();
    chk("dec_drained", empty, 1'b1);

    // Decrypt rollback behind committed encrypt words
    wr_enc(32'hB0, 1'b0);
    wr_enc(32'hB1, 1'b1);
    wr_dec(32'hC0, 1'b0, 1'b1);
    wr_dec(32'hC1, 1'b0, 1'b1);
    wr_dec(32'hC2, 1'b1, 1'b1);
    chk("rb_count_pre", count, 2);
    tag(1'b0, 1'b0);
    chk("rb_drop_pulse", drop_pulse, 1'b1);
    chk("rb_data_out_zero", data_out, 0);
    chk("rb_count", count, 2);
    chk("rb_w_ready", w_ready, 1'b1);
    idle();
    chk("rb_pulse_one_cycle", drop_pulse, 1'b0);
    rd();
    rd();
    chk("rb_empty", empty, 1'b1);
    wr_enc(32'hD0, 1'b1);
    chk("rb_wptr_restored", count, 1);
    rd();

    // Read and rollback in the same cycle: read owns data_out
    wr_enc(32'hE0, 1'b1);
    wr_dec(32'hE1, 1'b0, 1'b1);
    wr_dec(32'hE2, 1'b1, 1'b1);
    tag(1'b0, 1'b1);
    chk("rbrd_drop_pulse", drop_pulse, 1'b1);
    chk("rbrd_data_out", data_out, 32'hE0);
    chk("rbrd_count", count, 0);

    // Full and pointer wrap
    for (int i = 0; i < 8; i++) wr_enc(32'hF0 + i, (i == 7));
    chk("full_set", full, 1'b1);
    chk("full_w_ready", w_ready, 1'b0);
    chk("full_count", count, 8);
    wr_drop(32'hEE);
    chk("full_drop_count", count, 8);
    repeat (8) rd();
    chk("wrap_empty", empty, 1'b1);
    chk("wrap_not_full", full, 1'b0);
    for (int i = 0; i < 8; i++) wr_enc(32'h100 + i, (i == 7));
    chk("wrap_full", full, 1'b1);
    rd();
    cyc(1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(32'h200);
    chk("rdwr_count", count, 7);
    repeat (7) rd();
    chk("wrap_drained", empty, 1'b1);

    // Reset in WAIT_TAG discards committed and speculative words
    for (int i = 0; i < 5; i++) wr_enc(32'h30 + i, (i == 4));
    wr_dec(32'h40, 1'b0, 1'b1);
    wr_dec(32'h41, 1'b1, 1'b1);
    chk("mid_count", count, 5);
    chk("mid_pending", pkt_pending, 1'b1);
    do_reset();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_state", fsm_state, 0);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_w_ready", w_ready, 1'b1);
    tag(1'b1, 1'b0);
    chk("mid_late_tag", count, 0);
    rd();
    chk("mid_no_read", data_valid, 1'b0);

`ifdef FIFO_DROP_CNT_EN
    // Drop counter and saturation
    chk("dc_reset", drop_count, 0);
    for (int i = 0; i < 3; i++) begin
      wr_dec(32'h50 + i, 1'b1, 1'b1);
      tag(1'b0, 1'b0);
    end
    idle();
    chk("dc_three", drop_count, 3);
    force dut.drop_count = 16'hFFFF;
    idle();
    release dut.drop_count;
    wr_dec(32'h60, 1'b1, 1'b1);
    tag(1'b0, 1'b0);
    idle();
    idle();
    chk("dc_saturate", drop_count, 16'hFFFF);
`endif

    idle();
    idle();
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
